// File: rtl/feat_pkg.sv
// Shared definitions for the cepstral feature pipeline: default widths,
// block-state codes (matching the derivative stage) and the output beat layout.
package feat_pkg;

    localparam int FEAT_DATA_W = 32;
    localparam int FEAT_N_COEF = 13;
    localparam int FEAT_IDX_W  = 4;

    typedef enum logic [1:0] {
        S_CEP   = 2'b00,
        S_DCEP  = 2'b01,
        S_DDCEP = 2'b10
    } state_t;

    typedef struct packed {
        logic [FEAT_DATA_W-1:0] cep;
        logic [FEAT_DATA_W-1:0] dcep;
        logic [FEAT_DATA_W-1:0] ddcep;
        logic [FEAT_IDX_W-1:0]  idx;
    } beat_t;

endpackage

// File: rtl/feat_skid2.sv
// Two-entry FIFO skid buffer with valid/ready output and a full flag.
// The producer has no backpressure: the caller decides what to do with a push
// that arrives while full and nothing is leaving.
module feat_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         full
);

    logic [W-1:0] mem_q [2];
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         pop;
    logic         accept;
    logic         wr_ptr;

    assign out_valid = (cnt_q != 2'd0);
    assign full      = (cnt_q == 2'd2);
    assign pop       = out_valid & pop_ready;
    // a push while full is still taken when the head leaves in the same cycle
    assign accept    = push & (~full | pop);
    // write slot is the one after the tail; with 0 or 2 entries it coincides with rd_q
    assign wr_ptr    = rd_q ^ (cnt_q == 2'd1);
    assign out_data  = mem_q[rd_q];

    // storage, read pointer and occupancy; entries are cleared so idle outputs read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr] <= push_data;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, accept} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/feature_unpacker.sv
// Re-aligns the serial cep / delta / delta-delta word stream into one beat per
// coefficient index for the classifier.
// Optional statistics counters (frames_done, drops) are built when
// FEAT_UNPACK_STATS_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_CEP   | capturing cepstral words into cep_mem
// S_DCEP  | capturing delta words into dcep_mem
// S_DDCEP | each delta-delta word completes a beat, pushed to the skid
module feature_unpacker
    import feat_pkg::*;
#(
    parameter int DATA_W = FEAT_DATA_W,
    parameter int N_COEF = FEAT_N_COEF,
    parameter int IDX_W  = FEAT_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sync_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_cep,
    output logic [DATA_W-1:0] out_dcep,
    output logic [DATA_W-1:0] out_ddcep,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              overflow
`ifdef FEAT_UNPACK_STATS_EN
    ,
    output logic [15:0]       frames_done,
    output logic [15:0]       drops
`endif
);

    localparam int AW     = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam int BEAT_W = 3 * DATA_W + IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEF - 1);

    state_t            state_q, state_d, state_eff;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_eff;
    logic              idx_at_last;
    logic              cep_we, dcep_we, push;
    logic [AW-1:0]     wa;
    logic [DATA_W-1:0] cep_mem  [N_COEF];
    logic [DATA_W-1:0] dcep_mem [N_COEF];
    logic [BEAT_W-1:0] push_data, skid_data;
    logic              skid_full;
    logic              drop;

    // block/index sequencing; sync forces word 0 of a new frame before classification
    always_comb begin
        state_eff   = sync_in ? S_CEP : state_q;
        idx_eff     = sync_in ? '0 : idx_q;
        state_d     = state_eff;
        idx_d       = idx_eff;
        cep_we      = 1'b0;
        dcep_we     = 1'b0;
        push        = 1'b0;
        idx_at_last = (idx_eff == IDX_LAST);
        if (valid_in) begin
            idx_d = idx_at_last ? '0 : idx_eff + IDX_W'(1);
            case (state_eff)
                S_CEP: begin
                    cep_we = 1'b1;
                    if (idx_at_last) state_d = S_DCEP;
                end
                S_DCEP: begin
                    dcep_we = 1'b1;
                    if (idx_at_last) state_d = S_DDCEP;
                end
                S_DDCEP: begin
                    push = 1'b1;
                    if (idx_at_last) state_d = S_CEP;
                end
                default: begin
                    state_d = S_CEP;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // state and index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CEP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign wa = idx_eff[AW-1:0];

    // coefficient storage; never reset, beats only read slots written this frame
    always_ff @(posedge clk) begin
        if (cep_we)  cep_mem[wa]  <= data_in;
        if (dcep_we) dcep_mem[wa] <= data_in;
    end

    assign push_data = {cep_mem[wa], dcep_mem[wa], data_in, idx_eff, idx_at_last};
    assign drop      = push & skid_full & ~(out_valid & out_ready);

    feat_skid2 #(
        .W (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (skid_data),
        .full      (skid_full)
    );

    assign {out_cep, out_dcep, out_ddcep, out_idx, out_last} = skid_data;

    // sticky record of any beat lost to a full skid
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef FEAT_UNPACK_STATS_EN
    // wrapping counts of completed frames delivered and of dropped beats
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_done <= '0;
            drops       <= '0;
        end else begin
            if (out_valid & out_ready & out_last) frames_done <= frames_done + 16'd1;
            if (drop) drops <= drops + 16'd1;
        end
    end
`else
    // statistics counters not built
`endif

endmodule

// File: tb/tb_feature_unpacker.sv
// Scoreboard bench for feature_unpacker with N_COEF=3.
// Expected beats are queued as DD words are driven, modelling the 2-deep skid.
module tb_feature_unpacker;
    import feat_pkg::*;

    localparam int DW = 32;
    localparam int NC = 3;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          sync_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_cep, out_dcep, out_ddcep;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          overflow;
`ifdef FEAT_UNPACK_STATS_EN
    logic [15:0]   frames_done;
    logic [15:0]   drops;
`endif

    always #5 clk = ~clk;

    feature_unpacker #(
        .DATA_W (DW),
        .N_COEF (NC),
        .IDX_W  (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sync_in   (sync_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cep   (out_cep),
        .out_dcep  (out_dcep),
        .out_ddcep (out_ddcep),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overflow  (overflow)
`ifdef FEAT_UNPACK_STATS_EN
        ,
        .frames_done (frames_done),
        .drops       (drops)
`endif
    );

    typedef struct {
        beat_t b;
        logic  last;
    } exp_t;

    exp_t          q[$];
    exp_t          none;
    int            total = 0;
    int            bad = 0;
    logic          ovf_exp;
    int            frames_exp;
    int            drops_exp;
    logic          rdy;
    logic [DW-1:0] fc [NC];
    logic [DW-1:0] fd [NC];
    logic [DW-1:0] fdd [NC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] c, input logic [DW-1:0] dc,
                                input logic [DW-1:0] dd, input int i);
        exp_t e;
        e.b.cep   = c;
        e.b.dcep  = dc;
        e.b.ddcep = dd;
        e.b.idx   = IW'(i);
        e.last    = (i == NC - 1);
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_cep",   64'(out_cep),   64'(q[0].b.cep));
            chk("out_dcep",  64'(out_dcep),  64'(q[0].b.dcep));
            chk("out_ddcep", 64'(out_ddcep), 64'(q[0].b.ddcep));
            chk("out_idx",   64'(out_idx),   64'(q[0].b.idx));
            chk("out_last",  64'(out_last),  64'(q[0].last));
        end
        chk("overflow", 64'(overflow), 64'(ovf_exp));
`ifdef FEAT_UNPACK_STATS_EN
        chk("frames_done", 64'(frames_done), 64'(16'(frames_exp)));
        chk("drops",       64'(drops),       64'(16'(drops_exp)));
`endif
    endtask

    // one cycle: check outputs, drive inputs, update the skid model, advance
    task automatic step(input logic v, input logic [DW-1:0] d, input logic s,
                        input logic pu, input exp_t e);
        logic pop;
        check_outputs();
        out_ready = rdy;
        pop       = (q.size() != 0) && rdy;
        valid_in  = v;
        data_in   = d;
        sync_in   = s;
        if (pop) begin
            if (q[0].last) frames_exp++;
            void'(q.pop_front());
        end
        if (pu) begin
            if (q.size() < 2) q.push_back(e);
            else begin
                ovf_exp = 1'b1;
                drops_exp++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, none);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic s, input logic pu,
                             input exp_t e, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        idle(g);
        step(1'b1, d, s, pu, e);
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < NC; i++) send_word(fc[i], 1'b0, 1'b0, none, max_gap);
        for (int i = 0; i < NC; i++) send_word(fd[i], 1'b0, 1'b0, none, max_gap);
        for (int i = 0; i < NC; i++)
            send_word(fdd[i], 1'b0, 1'b1, mk(fc[i], fd[i], fdd[i], i), max_gap);
    endtask

    task automatic set_frame(input int base);
        for (int i = 0; i < NC; i++) begin
            fc[i]  = DW'(base + i + 1);
            fd[i]  = DW'(10 * (base + i + 1));
            fdd[i] = DW'(-(base + i + 1));
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        sync_in  = 1'b0;
        data_in  = '0;
        q.delete();
        ovf_exp    = 1'b0;
        frames_exp = 0;
        drops_exp  = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid",    64'(out_valid), 64'(0));
        chk("rst_overflow", 64'(overflow),  64'(0));
        chk("rst_cep",      64'(out_cep),   64'(0));
        chk("rst_idx",      64'(out_idx),   64'(0));
        chk("rst_last",     64'(out_last),  64'(0));
`ifdef FEAT_UNPACK_STATS_EN
        chk("rst_frames", 64'(frames_done), 64'(0));
        chk("rst_drops",  64'(drops),       64'(0));
`endif
    endtask

    initial begin
        none.b    = '0;
        none.last = 1'b0;
        rdy       = 1'b1;
        out_ready = 1'b1;
        rst       = 1'b1;
        valid_in  = 1'b0;
        sync_in   = 1'b0;
        data_in   = '0;
        @(negedge clk);
        do_reset();

        // contiguous frame 1,2,3 / 10,20,30 / -1,-2,-3
        set_frame(0);
        send_frame(0);
        idle(4);

        // same frame with random gaps
        for (int r = 0; r < 3; r++) begin
            send_frame(3);
            idle(4);
        end

        // consumer stalled through the whole DD block: third beat dropped
        set_frame(4);
        rdy = 1'b0;
        send_frame(0);
        idle(2);
        rdy = 1'b1;
        idle(5);

        // resync mid-delta block; 7 becomes cep[0]
        set_frame(20);
        for (int i = 0; i < NC; i++) send_word(fc[i], 1'b0, 1'b0, none, 0);
        send_word(fd[0], 1'b0, 1'b0, none, 0);
        fc[0] = 32'd7;
        send_word(fc[0], 1'b1, 1'b0, none, 0);
        for (int i = 1; i < NC; i++) send_word(fc[i], 1'b0, 1'b0, none, 1);
        for (int i = 0; i < NC; i++) send_word(fd[i], 1'b0, 1'b0, none, 1);
        for (int i = 0; i < NC; i++)
            send_word(fdd[i], 1'b0, 1'b1, mk(fc[i], fd[i], fdd[i], i), 1);
        set_frame(30);
        send_frame(1);
        idle(4);

        // reset mid DD block with one beat buffered
        set_frame(40);
        rdy = 1'b0;
        for (int i = 0; i < NC; i++) send_word(fc[i], 1'b0, 1'b0, none, 0);
        for (int i = 0; i < NC; i++) send_word(fd[i], 1'b0, 1'b0, none, 0);
        send_word(fdd[0], 1'b0, 1'b1, mk(fc[0], fd[0], fdd[0], 0), 0);
        idle(1);
        do_reset();
        rdy = 1'b1;
        set_frame(50);
        send_frame(2);
        idle(4);

`ifdef FEAT_UNPACK_STATS_EN
        // one frame losing its last beat, then three clean frames
        do_reset();
        set_frame(60);
        rdy = 1'b0;
        send_frame(0);
        rdy = 1'b1;
        idle(4);
        for (int r = 0; r < 3; r++) begin
            set_frame(70 + 5 * r);
            send_frame(1);
        end
        idle(4);
        chk("stats_frames", 64'(frames_done), 64'(3));
        chk("stats_drops",  64'(drops),       64'(1));
        do_reset();
`endif

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
